// File: rtl/prog_byte_loader.sv
// Synchronises the async strobe and program-enable pins, then buffers strobed bytes in a small FIFO
// and hands them out tagged with RAM addresses over valid/ready.
module prog_byte_loader #(
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4,
  parameter int MEM_WORDS   = 16,
  parameter int ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        ui_in,
  input  logic              ext_strobe,
  input  logic              prog_en_pin,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [7:0]        out_byte,
  output logic [ADDR_W-1:0] out_addr,
  output logic              programming,
  output logic              done,
  output logic              overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]     FIFO_FULL = (PW+1)'(DEPTH);
  localparam logic [ADDR_W:0] MEM_CNT   = (ADDR_W+1)'(MEM_WORDS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]             state;
  logic [SYNC_STAGES-1:0] strb_sync;
  logic [SYNC_STAGES-1:0] en_sync;
  logic                   strb_h;
  logic                   en_h;
  logic                   strb_s;
  logic                   en_s;
  logic                   strb_rise;
  logic                   en_rise;
  logic                   en_fall;

  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     occ;
  logic [ADDR_W:0] count;
  logic [ADDR_W:0] count_nxt;

  logic empty;
  logic full;
  logic active;
  logic pop;
  logic push_req;
  logic push;
  logic drop;

  assign strb_s    = strb_sync[SYNC_STAGES-1];
  assign en_s      = en_sync[SYNC_STAGES-1];
  assign strb_rise = strb_s & ~strb_h;
  assign en_rise   = en_s & ~en_h;
  assign en_fall   = ~en_s & en_h;

  assign empty     = (occ == '0);
  assign full      = (occ == FIFO_FULL);
  assign active    = (state == S_LOAD) || (state == S_DRAIN);
  assign out_valid = !empty && active;
  assign pop       = out_valid && out_ready;

  // Once the session has taken MEM_WORDS bytes, further strobes are simply ignored (no overflow).
  assign push_req  = (state == S_LOAD) && strb_rise && (count != MEM_CNT);
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;
  assign count_nxt = count + {{ADDR_W{1'b0}}, push};

  assign out_byte    = out_valid ? mem[rd_ptr] : 8'h00;
  assign programming = active;
  assign done        = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ui_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      strb_sync <= '0;
      en_sync   <= '0;
      strb_h    <= 1'b0;
      en_h      <= 1'b0;
    end else begin
      strb_sync <= {strb_sync[SYNC_STAGES-2:0], ext_strobe};
      en_sync   <= {en_sync[SYNC_STAGES-2:0], prog_en_pin};
      strb_h    <= strb_s;
      en_h      <= en_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (PW+1)'(1);
        2'b01:   occ <= occ - (PW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      count    <= '0;
      out_addr <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) out_addr <= out_addr + ADDR_W'(1);
      case (state)
        S_IDLE: begin
          if (en_rise) begin
            state    <= S_LOAD;
            count    <= '0;
            out_addr <= '0;
            overflow <= 1'b0;
          end
        end
        S_LOAD: begin
          count <= count_nxt;
          if (drop) overflow <= 1'b1;
          // A push on the exit cycle is still taken; DRAIN then flushes it.
          if ((count_nxt == MEM_CNT) || en_fall) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (empty) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_byte_loader.sv
// Directed bench for prog_byte_loader: expected bytes/addresses queued at stimulus time,
// popped and compared by a monitor on every accepted transfer.
module tb_prog_byte_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ui_in;
  logic       ext_strobe;
  logic       prog_en_pin;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_byte;
  logic [3:0] out_addr;
  logic       programming;
  logic       done;
  logic       overflow;

  typedef struct packed {
    logic [7:0] b;
    logic [3:0] a;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] exp_addr = 4'd0;
  int         tests    = 0;
  int         fails    = 0;
  int         done_cnt = 0;
  int         xfer_cnt = 0;

  prog_byte_loader #(.SYNC_STAGES(2), .DEPTH(4), .MEM_WORDS(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .ui_in      (ui_in),
    .ext_strobe (ext_strobe),
    .prog_en_pin(prog_en_pin),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_byte   (out_byte),
    .out_addr   (out_addr),
    .programming(programming),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_xfer: got %0h at addr %0h, expected no transfer", out_byte, out_addr);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("xfer_byte", {24'd0, out_byte}, {24'd0, e.b});
          chk("xfer_addr", {28'd0, out_addr}, {28'd0, e.a});
        end
      end
      if (!out_valid) chk("idle_byte_zero", {24'd0, out_byte}, 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b, input bit expect_push);
    ui_in = b;
    if (expect_push) begin
      sb.push_back(exp_t'{b, exp_addr});
      exp_addr = exp_addr + 4'd1;
    end
    ext_strobe = 1'b1;
    tick(2);
    ext_strobe = 1'b0;
    tick(3);
  endtask

  task automatic start_session();
    prog_en_pin = 1'b1;
    exp_addr    = 4'd0;
    tick(4);
    chk("session_programming", {31'd0, programming}, 32'd1);
  endtask

  task automatic wait_done(input int base, input string nm);
    for (int i = 0; i < 80; i++) begin
      if (done_cnt != base) break;
      tick(1);
    end
    tick(4);
    chk({nm, "_done_once"}, done_cnt - base, 32'd1);
    chk({nm, "_prog_off"}, {31'd0, programming}, 32'd0);
    chk({nm, "_sb_empty"}, sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int xbase;
    reset       = 1'b1;
    ui_in       = 8'h00;
    ext_strobe  = 1'b0;
    prog_en_pin = 1'b0;
    out_ready   = 1'b0;
    tick(3);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_byte", {24'd0, out_byte}, 32'd0);
    chk("rst_addr", {28'd0, out_addr}, 32'd0);
    chk("rst_prog", {31'd0, programming}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    tick(2);

    // T1: strobe latency, single byte
    start_session();
    base      = done_cnt;
    out_ready = 1'b1;
    ui_in     = 8'hA5;
    sb.push_back(exp_t'{8'hA5, 4'd0});
    exp_addr   = 4'd1;
    ext_strobe = 1'b1;
    tick(1);
    chk("t1_valid_e1", {31'd0, out_valid}, 32'd0);
    tick(1);
    chk("t1_valid_e2", {31'd0, out_valid}, 32'd0);
    tick(1);
    chk("t1_valid_e3", {31'd0, out_valid}, 32'd1);
    chk("t1_byte", {24'd0, out_byte}, 32'hA5);
    chk("t1_addr", {28'd0, out_addr}, 32'd0);
    ext_strobe = 1'b0;
    tick(1);
    chk("t1_addr_next", {28'd0, out_addr}, 32'd1);
    tick(3);
    prog_en_pin = 1'b0;
    wait_done(base, "t1");

    // T2: fill FIFO with ready low, fifth byte dropped
    start_session();
    base      = done_cnt;
    out_ready = 1'b0;
    strobe(8'h11, 1'b1);
    strobe(8'h22, 1'b1);
    strobe(8'h33, 1'b1);
    strobe(8'h44, 1'b1);
    chk("t2_ovf_before", {31'd0, overflow}, 32'd0);
    strobe(8'h55, 1'b0);
    chk("t2_ovf", {31'd0, overflow}, 32'd1);
    chk("t2_stall_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_stall_byte", {24'd0, out_byte}, 32'h11);
    chk("t2_stall_addr", {28'd0, out_addr}, 32'd0);
    out_ready = 1'b1;
    tick(8);
    chk("t2_drained", sb.size(), 32'd0);
    prog_en_pin = 1'b0;
    wait_done(base, "t2");
    chk("t2_ovf_sticky", {31'd0, overflow}, 32'd1);

    // T3: full 16-byte session, address wrap, 17th strobe ignored
    start_session();
    chk("t3_ovf_cleared", {31'd0, overflow}, 32'd0);
    base      = done_cnt;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) strobe(8'hC0 + 8'(i), 1'b1);
    strobe(8'hEE, 1'b0);
    chk("t3_ovf", {31'd0, overflow}, 32'd0);
    wait_done(base, "t3");
    chk("t3_addr_wrap", {28'd0, out_addr}, 32'd0);
    prog_en_pin = 1'b0;
    tick(4);

    // T4: enable drops with bytes pending and ready low
    start_session();
    base      = done_cnt;
    out_ready = 1'b0;
    strobe(8'h3C, 1'b1);
    strobe(8'hC3, 1'b1);
    prog_en_pin = 1'b0;
    tick(8);
    chk("t4_prog_held", {31'd0, programming}, 32'd1);
    chk("t4_no_done", done_cnt - base, 32'd0);
    chk("t4_head", {24'd0, out_byte}, 32'h3C);
    out_ready = 1'b1;
    wait_done(base, "t4");

    // T5: reset mid-LOAD with bytes queued
    start_session();
    out_ready = 1'b0;
    strobe(8'h01, 1'b0);
    strobe(8'h02, 1'b0);
    strobe(8'h03, 1'b0);
    chk("t5_queued", {31'd0, out_valid}, 32'd1);
    reset       = 1'b1;
    prog_en_pin = 1'b0;
    tick(1);
    chk("t5_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_byte", {24'd0, out_byte}, 32'd0);
    chk("t5_addr", {28'd0, out_addr}, 32'd0);
    chk("t5_prog", {31'd0, programming}, 32'd0);
    chk("t5_done", {31'd0, done}, 32'd0);
    chk("t5_ovf", {31'd0, overflow}, 32'd0);
    tick(1);
    reset = 1'b0;
    tick(3);
    out_ready = 1'b1;
    xbase     = xfer_cnt;
    strobe(8'h77, 1'b0);
    tick(3);
    chk("t5_ignored_xfer", xfer_cnt - xbase, 32'd0);
    chk("t5_ignored_prog", {31'd0, programming}, 32'd0);
    start_session();
    base = done_cnt;
    strobe(8'h88, 1'b1);
    tick(2);
    chk("t5_resume", sb.size(), 32'd0);
    prog_en_pin = 1'b0;
    wait_done(base, "t5");

    // T6: sub-cycle strobe pulse straddling one clock edge
    start_session();
    base      = done_cnt;
    out_ready = 1'b1;
    ui_in     = 8'h5A;
    sb.push_back(exp_t'{8'h5A, 4'd0});
    xbase = xfer_cnt;
    @(posedge clk);
    #7 ext_strobe = 1'b1;
    #6 ext_strobe = 1'b0;
    tick(10);
    chk("t6_one_xfer", xfer_cnt - xbase, 32'd1);
    prog_en_pin = 1'b0;
    wait_done(base, "t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
